prog_loader: RTL and testbench

Boot-time program loader sitting directly upstream of the multicycle RISC-V core's 32-bit instruction memory. Accepts a byte stream with a valid/ready handshake, packs bytes little-endian into 32-bit instruction words and writes them at consecutive word addresses into the instruction memory's write port. After the final byte is written, it raises `cpu_run`, which gates the core's active-low reset so execution starts at `BASE_ADDR`.

---
 rtl/prog_loader_pkg.sv | 5 +
 rtl/prog_loader.sv | 59 +++++
 tb/tb_prog_loader.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// loader_pkg: shared state encoding and word geometry for prog_loader
package loader_pkg;
  typedef enum logic [1:0] {COLLECT, WRITE, DONE, ERR} state_t;
  localparam int WORD_BYTES = 4;
endpackage

// File: rtl/prog_loader.sv
// prog_loader: packs a byte stream into 32-bit words and writes them to instruction memory
module prog_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int MAX_WORDS = 1024,
  parameter int CNT_W = $clog2(MAX_WORDS + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             mem_wr,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_data,
  output logic             cpu_run,
  output logic             load_err,
  output logic [CNT_W-1:0] words_loaded
);
  state_t state;
  logic [31:0] word_buf;
  logic [31:0] addr;
  logic [1:0] byte_cnt;
  logic last_tag;
  logic fire;
  assign in_ready = Reset && state == COLLECT;
  assign fire = in_valid && in_ready;
  assign mem_wr = state == WRITE;
  assign mem_addr = addr;
  assign mem_data = word_buf;
  assign cpu_run = state == DONE;
  assign load_err = state == ERR;
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= COLLECT;
      word_buf <= '0;
      addr <= BASE_ADDR;
      byte_cnt <= '0;
      last_tag <= 1'b0;
      words_loaded <= '0;
    end else if (fire) begin
      if (words_loaded == CNT_W'(MAX_WORDS)) state <= ERR;
      else begin
        word_buf[{byte_cnt, 3'b000} +: 8] <= in_data;
        byte_cnt <= byte_cnt + 2'd1;
        last_tag <= in_last;
        if (byte_cnt == 2'(WORD_BYTES - 1) || in_last) state <= WRITE;
      end
    end else if (state == WRITE) begin
      words_loaded <= words_loaded + CNT_W'(1);
      addr <= addr + 32'(WORD_BYTES);
      word_buf <= '0;
      byte_cnt <= '0;
      state <= last_tag ? DONE : COLLECT;
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized byte streams checked against a word-level model of the loader
module tb_prog_loader;
  logic Clk;
  logic rst_n[3], iv[3], il[3], ir[3], mw[3], run[3], err[3];
  logic [7:0] id[3];
  logic [31:0] ma[3], md[3];
  logic [10:0] wl[3];
  logic [7:0] sb[$];
  logic [63:0] wq[$];
  int passed = 0;
  int total = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  prog_loader #(.CNT_W(11)) dut0 (
    .Clk(Clk), .Reset(rst_n[0]), .in_valid(iv[0]), .in_data(id[0]), .in_last(il[0]),
    .in_ready(ir[0]), .mem_wr(mw[0]), .mem_addr(ma[0]), .mem_data(md[0]),
    .cpu_run(run[0]), .load_err(err[0]), .words_loaded(wl[0]));
  prog_loader #(.MAX_WORDS(2), .CNT_W(11)) dut1 (
    .Clk(Clk), .Reset(rst_n[1]), .in_valid(iv[1]), .in_data(id[1]), .in_last(il[1]),
    .in_ready(ir[1]), .mem_wr(mw[1]), .mem_addr(ma[1]), .mem_data(md[1]),
    .cpu_run(run[1]), .load_err(err[1]), .words_loaded(wl[1]));
  prog_loader #(.BASE_ADDR(32'h100), .CNT_W(11)) dut2 (
    .Clk(Clk), .Reset(rst_n[2]), .in_valid(iv[2]), .in_data(id[2]), .in_last(il[2]),
    .in_ready(ir[2]), .mem_wr(mw[2]), .mem_addr(ma[2]), .mem_data(md[2]),
    .cpu_run(run[2]), .load_err(err[2]), .words_loaded(wl[2]));

  always @(posedge Clk)
    for (int i = 0; i < 3; i++) if (mw[i]) wq.push_back({ma[i], md[i]});

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic do_reset(input int d, input logic [31:0] base);
    rst_n[d] = 1'b0;
    iv[d] = 1'b1;
    id[d] = 8'hEE;
    il[d] = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_ready", 64'(ir[d]), 64'(0));
    chk("rst_wr", 64'(mw[d]), 64'(0));
    chk("rst_addr", 64'(ma[d]), 64'(base));
    chk("rst_data", 64'(md[d]), 64'(0));
    chk("rst_run", 64'(run[d]), 64'(0));
    chk("rst_err", 64'(err[d]), 64'(0));
    chk("rst_words", 64'(wl[d]), 64'(0));
    wq.delete();
    rst_n[d] = 1'b1;
    iv[d] = 1'b0;
  endtask

  task automatic run_stream(input int d, input logic [31:0] base, input int maxw,
                            input bit rnd, input int budget, input bit post_valid);
    int n, nw, nwr, acc, idx, fires;
    bit e, f, prev_wr;
    logic [31:0] wd;
    logic [63:0] eq[$];
    n = sb.size();
    nw = (n + 3) / 4;
    e = nw > maxw;
    nwr = e ? maxw : nw;
    acc = e ? 4 * maxw + 1 : n;
    for (int w = 0; w < nwr; w++) begin
      wd = '0;
      for (int k = 0; k < 4; k++) if (4 * w + k < n) wd[8 * k +: 8] = sb[4 * w + k];
      eq.push_back({base + 32'(4 * w), wd});
    end
    do_reset(d, base);
    idx = 0;
    fires = 0;
    prev_wr = 1'b0;
    for (int c = 0; c < budget; c++) begin
      iv[d] = idx < n ? (rnd ? 1'($urandom) : 1'b1) : post_valid;
      id[d] = idx < n ? sb[idx] : 8'($urandom);
      il[d] = idx < n ? (idx == n - 1) : 1'($urandom);
      #4;
      chk("ready_only_outside_write", 64'(ir[d]), 64'(!mw[d] && !run[d] && !err[d]));
      if (prev_wr) chk("run_after_write", 64'(run[d]), 64'(wq.size() == nwr && !e));
      prev_wr = mw[d];
      f = iv[d] && ir[d];
      @(posedge Clk);
      #1;
      if (f) begin
        fires++;
        if (idx < n) idx++;
      end
    end
    iv[d] = 1'b0;
    chk("accepted_bytes", 64'(fires), 64'(acc));
    chk("write_count", 64'(wq.size()), 64'(nwr));
    for (int w = 0; w < nwr && w < wq.size(); w++) chk("write_addr_data", wq[w], eq[w]);
    chk("words_loaded", 64'(wl[d]), 64'(nwr));
    chk("cpu_run", 64'(run[d]), 64'(!e));
    chk("load_err", 64'(err[d]), 64'(e));
    chk("ready_final", 64'(ir[d]), 64'(0));
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0;
      iv[i] = 1'b0;
      id[i] = 8'h00;
      il[i] = 1'b0;
    end
    sb = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00};
    run_stream(0, 32'h0, 1024, 1'b0, 20, 1'b0);
    chk("known_word0", wq.size() > 0 ? wq[0] : 64'hX, {32'h0, 32'h00500513});
    chk("known_word1", wq.size() > 1 ? wq[1] : 64'hX, {32'h4, 32'h00A00593});
    run_stream(0, 32'h0, 1024, 1'b1, 60, 1'b0);
    sb = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hAA, 8'hBB};
    run_stream(0, 32'h0, 1024, 1'b0, 20, 1'b1);
    chk("partial_word", wq.size() > 1 ? wq[1] : 64'hX, {32'h4, 32'h0000BBAA});
    sb = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
    run_stream(1, 32'h0, 2, 1'b0, 30, 1'b1);
    do_reset(0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      iv[0] = 1'b1;
      id[0] = 8'(8'hA0 + i);
      il[0] = 1'b0;
      @(posedge Clk);
      #1;
    end
    rst_n[0] = 1'b0;
    @(posedge Clk);
    #1;
    chk("midload_no_write", 64'(wq.size()), 64'(0));
    chk("midload_data_cleared", 64'(md[0]), 64'(0));
    chk("midload_words", 64'(wl[0]), 64'(0));
    sb = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_stream(0, 32'h0, 1024, 1'b0, 12, 1'b1);
    chk("reload_word", wq.size() > 0 ? wq[0] : 64'hX, {32'h0, 32'h44332211});
    run_stream(2, 32'h100, 1024, 1'b0, 110, 1'b1);
    for (int r = 0; r < 3; r++) begin
      sb.delete();
      repeat ($urandom_range(40, 1)) sb.push_back(8'($urandom));
      run_stream(0, 32'h0, 1024, 1'b1, 240, 1'b1);
    end
    sb.delete();
    repeat ($urandom_range(30, 5)) sb.push_back(8'($urandom));
    run_stream(2, 32'h100, 1024, 1'b1, 200, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
